clk_gate_ctrl: RTL and testbench



---
 rtl/clocking_pkg.sv | 25 ++
 rtl/clk_gate_ctrl.sv | 95 +++++++++
 tb/tb_clk_gate_ctrl.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/clocking_pkg.sv
// Shared clocking definitions: gate-controller state type, state_o encodings
// and output-decode helpers.
package clocking_pkg;

    typedef enum logic [1:0] {
        CG_OFF  = 2'd0,
        CG_WAKE = 2'd1,
        CG_ON   = 2'd2,
        CG_IDLE = 2'd3
    } clk_gate_ctrl_state_e;

    localparam logic [1:0] CG_STATE_OFF  = 2'd0;
    localparam logic [1:0] CG_STATE_WAKE = 2'd1;
    localparam logic [1:0] CG_STATE_ON   = 2'd2;
    localparam logic [1:0] CG_STATE_IDLE = 2'd3;

    function automatic logic cg_gate_open(input clk_gate_ctrl_state_e s);
        return (s != CG_OFF);
    endfunction

    function automatic logic cg_clock_live(input clk_gate_ctrl_state_e s);
        return (s == CG_ON) || (s == CG_IDLE);
    endfunction

endpackage

// File: rtl/clk_gate_ctrl.sv
// Clock-gating controller: opens the gate on activity, acknowledges after the
// synchronizer latency, and closes it after a programmable idle period.
module clk_gate_ctrl
    import clocking_pkg::*;
#(
    parameter int unsigned IDLE_CYCLES = 16,
    parameter int unsigned WAKE_CYCLES = 2
) (
    input  logic       clk_i,
    input  logic       arst_ni,
    input  logic       req_i,
    input  logic       busy_i,
    input  logic       force_on_i,
    output logic       gate_en_o,
    output logic       ack_o,
    output logic [1:0] state_o
);

    localparam int unsigned MAX_CYCLES = (IDLE_CYCLES > WAKE_CYCLES) ? IDLE_CYCLES : WAKE_CYCLES;
    localparam int unsigned CW         = $clog2(MAX_CYCLES + 1);

    localparam logic [CW-1:0] WAKE_LOAD = CW'(WAKE_CYCLES - 1);
    localparam logic [CW-1:0] IDLE_LOAD = CW'(IDLE_CYCLES - 1);

    clk_gate_ctrl_state_e state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 gate_en_q, gate_en_d;
    logic                 ack_q, ack_d;
    logic                 act;

    always_comb begin
        act     = req_i | busy_i | force_on_i;
        state_d = state_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            CG_OFF: begin
                if (act) begin
                    state_d = CG_WAKE;
                    cnt_d   = WAKE_LOAD;
                end
            end
            // Wake always completes; activity is not sampled here.
            CG_WAKE: begin
                if (cnt_q == '0) begin
                    state_d = CG_ON;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            CG_ON: begin
                if (!act) begin
                    state_d = CG_IDLE;
                    cnt_d   = IDLE_LOAD;
                end
            end
            CG_IDLE: begin
                if (act) begin
                    state_d = CG_ON;
                end else if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    state_d = CG_OFF;
                end
            end
            default: begin
                state_d = CG_OFF;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered from the next state so they align with state_q.
        gate_en_d = cg_gate_open(state_d);
        ack_d     = cg_clock_live(state_d);
    end

    always_ff @(posedge clk_i or negedge arst_ni) begin
        if (!arst_ni) begin
            state_q   <= CG_OFF;
            cnt_q     <= '0;
            gate_en_q <= 1'b0;
            ack_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            gate_en_q <= gate_en_d;
            ack_q     <= ack_d;
        end
    end

    assign gate_en_o = gate_en_q;
    assign ack_o     = ack_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_clk_gate_ctrl.sv
// Self-checking bench for clk_gate_ctrl: directed scenarios plus randomized
// activity, compared against a cycle-counting behavioural model.
module tb_clk_gate_ctrl;

    localparam int unsigned IDLE_N = 16;
    localparam int unsigned WAKE_N = 2;

    logic       clk;
    logic       arst_n;
    logic       req, busy, frc;
    logic       gate_en, ack;
    logic [1:0] state;

    int unsigned tests = 0;
    int unsigned fails = 0;

    // Behavioural model: clock powered or not, cycles of wake still pending,
    // and length of the current run of inactive edges since reaching ON.
    bit m_powered;
    int m_wake_left;
    int m_run;

    clk_gate_ctrl #(
        .IDLE_CYCLES(IDLE_N),
        .WAKE_CYCLES(WAKE_N)
    ) dut (
        .clk_i      (clk),
        .arst_ni    (arst_n),
        .req_i      (req),
        .busy_i     (busy),
        .force_on_i (frc),
        .gate_en_o  (gate_en),
        .ack_o      (ack),
        .state_o    (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        m_powered   = 1'b0;
        m_wake_left = 0;
        m_run       = 0;
    endtask

    task automatic model_edge(input bit act);
        if (!m_powered) begin
            if (act) begin
                m_powered   = 1'b1;
                m_wake_left = WAKE_N;
                m_run       = 0;
            end
        end else if (m_wake_left > 0) begin
            m_wake_left--;
        end else begin
            m_run = act ? 0 : m_run + 1;
            // Gate closes on the inactive edge after the idle count is used up.
            if (m_run == IDLE_N + 1) begin
                m_powered = 1'b0;
                m_run     = 0;
            end
        end
    endtask

    task automatic check_bit(input string tag, input logic got, input logic exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0b exp=%0b", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [1:0] exp_state;
        if (!m_powered)           exp_state = 2'd0;
        else if (m_wake_left > 0) exp_state = 2'd1;
        else if (m_run > 0)       exp_state = 2'd3;
        else                      exp_state = 2'd2;
        tests++;
        assert (state === exp_state) else begin
            fails++;
            $error("FAIL %s state got=%0d exp=%0d", tag, state, exp_state);
        end
        check_bit({tag, ".gate_en"}, gate_en, m_powered);
        check_bit({tag, ".ack"}, ack, m_powered && (m_wake_left == 0));
    endtask

    task automatic tick(input string tag, input logic r, input logic b, input logic f);
        req  = r;
        busy = b;
        frc  = f;
        @(posedge clk);
        model_edge(r | b | f);
        #1;
        check_all(tag);
    endtask

    // Reset asserted between edges; outputs must clear without a clock edge.
    task automatic async_reset(input string tag);
        #3;
        arst_n = 1'b0;
        #1;
        model_reset();
        check_bit({tag, ".gate_en0"}, gate_en, 1'b0);
        check_bit({tag, ".ack0"}, ack, 1'b0);
        tests++;
        assert (state === 2'd0) else begin
            fails++;
            $error("FAIL %s.state0 got=%0d exp=0", tag, state);
        end
        @(negedge clk);
        arst_n = 1'b1;
    endtask

    initial begin
        int unsigned ack_cycles;
        model_reset();
        arst_n = 1'b0;
        req    = 1'b1;
        busy   = 1'b0;
        frc    = 1'b0;

        // Reset held with req high.
        repeat (3) begin
            @(posedge clk);
            #1;
            check_all("rst_hold");
        end
        @(negedge clk);
        arst_n = 1'b1;
        tick("rst_rel1", 1, 0, 0);
        check_bit("rst_gate_first_edge", gate_en, 1'b1);
        check_bit("rst_ack_first_edge", ack, 1'b0);
        tick("rst_rel2", 1, 0, 0);
        tick("rst_rel3", 1, 0, 0);
        check_bit("rst_ack_two_later", ack, 1'b1);

        // Idle close: 16 low edges keep ack, the 17th closes.
        for (int i = 0; i < 16; i++) tick("idle_close", 0, 0, 0);
        check_bit("idle_close_ack_j15", ack, 1'b1);
        tick("idle_close_exp", 0, 0, 0);
        check_bit("idle_close_gate_off", gate_en, 1'b0);

        // Idle rescue on the expiry edge, then a full countdown restarts.
        tick("rescue_wake", 0, 1, 0);
        tick("rescue_wake", 0, 1, 0);
        tick("rescue_wake", 0, 1, 0);
        for (int i = 0; i < 16; i++) tick("rescue_cnt", 0, 0, 0);
        tick("rescue_hit", 0, 1, 0);
        check_bit("rescue_gate_held", gate_en, 1'b1);
        tests++;
        assert (state === 2'd2) else begin
            fails++;
            $error("FAIL rescue_state got=%0d exp=2", state);
        end
        for (int i = 0; i < 16; i++) tick("rescue_recnt", 0, 0, 0);
        check_bit("rescue_recnt_ack", ack, 1'b1);
        tick("rescue_close", 0, 0, 0);
        tick("rescue_off", 0, 0, 0);

        // Abort-free wake from a 1-cycle pulse; count ack-high cycles.
        ack_cycles = 0;
        tick("pulse", 1, 0, 0);
        for (int i = 0; i < 24; i++) begin
            tick("pulse_run", 0, 0, 0);
            if (ack === 1'b1) ack_cycles++;
        end
        tests++;
        assert (ack_cycles == 17) else begin
            fails++;
            $error("FAIL pulse_ack_cycles got=%0d exp=17", ack_cycles);
        end

        // Force-on for 100 cycles then release.
        for (int i = 0; i < 100; i++) tick("force", 0, 0, 1);
        for (int i = 0; i < 17; i++) tick("force_rel", 0, 0, 0);
        check_bit("force_rel_off", gate_en, 1'b0);

        // Asynchronous reset mid-WAKE and mid-IDLE.
        tick("ar_wake", 1, 0, 0);
        async_reset("ar_mid_wake");
        tick("ar_w2", 0, 1, 0);
        tick("ar_w3", 0, 0, 0);
        tick("ar_w4", 0, 0, 0);
        tick("ar_w5", 0, 0, 0);
        for (int i = 0; i < 5; i++) tick("ar_idle", 0, 0, 0);
        async_reset("ar_mid_idle");

        // Randomized activity with occasional force bursts and async resets.
        for (int i = 0; i < 1500; i++) begin
            logic r, b, f;
            r = ($urandom_range(0, 11) == 0);
            b = ($urandom_range(0, 17) == 0);
            f = ((i / 200) % 3 == 2) && ($urandom_range(0, 3) != 0);
            tick("rand", r, b, f);
            if ($urandom_range(0, 249) == 0) async_reset("rand_ar");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
